// File: rtl/v68k_pkg.sv
// Shared 68k datapath definitions: MOVEM sequencer state encoding and
// register-file index/mask widths.
package v68k_pkg;

  localparam int unsigned REG_IDX_W  = 4;
  localparam int unsigned REG_MASK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } movem_state_t;

endpackage

// File: rtl/movem_mask_sequencer_if.sv
// Control-unit <-> MOVEM sequencer bundle. The count signal exists only
// when MOVEM_COUNT_EN is defined.
interface movem_mask_sequencer_if #(
  parameter int unsigned N = v68k_pkg::REG_IDX_W
) ();

  localparam int unsigned W = 1 << N;

  logic         start;
  logic [W-1:0] mask;
  logic         predec;
  logic [N-1:0] idx;
  logic         idx_valid;
  logic         idx_ready;
  logic         busy;
  logic         done;
`ifdef MOVEM_COUNT_EN
  logic [N:0]   count;

  modport master (
    output start, mask, predec, idx_ready,
    input  idx, idx_valid, busy, done, count
  );

  modport slave (
    input  start, mask, predec, idx_ready,
    output idx, idx_valid, busy, done, count
  );
`else
  modport master (
    output start, mask, predec, idx_ready,
    input  idx, idx_valid, busy, done
  );

  modport slave (
    input  start, mask, predec, idx_ready,
    output idx, idx_valid, busy, done
  );
`endif

endinterface

// File: rtl/priority_encoder.sv
// Priority encoder, the inverse of the register-select decoder: returns the
// index of the lowest (or highest, msb_first=1) set bit and whether any bit is set.
module priority_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [(1<<N)-1:0] mask,
  input  logic              msb_first,
  output logic [N-1:0]      index,
  output logic              any
);

  localparam int unsigned W = 1 << N;

  // Last match in the loop wins, so the scan direction is opposite to the priority.
  always_comb begin
    index = '0;
    if (msb_first) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (mask[i]) index = N'(i);
      end
    end else begin
      for (int unsigned i = W; i > 0; i--) begin
        if (mask[i-1]) index = N'(i - 1);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/movem_mask_sequencer.sv
// Walks a MOVEM register mask, one register index per accepted handshake.
// Define MOVEM_COUNT_EN to add the accepted-transfer counter.
module movem_mask_sequencer
  import v68k_pkg::*;
#(
  parameter int unsigned N = REG_IDX_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  movem_mask_sequencer_if.slave  bus
);

  localparam int unsigned W = 1 << N;

  movem_state_t state;
  logic [W-1:0] pending;
  logic [W-1:0] pending_next;
  logic         dir;
  logic [N-1:0] enc_idx;
  logic         enc_any;
  logic         valid;
`ifdef MOVEM_COUNT_EN
  logic [N:0]   count;
`endif

  priority_encoder #(.N(N)) u_penc (
    .mask      (pending),
    .msb_first (dir),
    .index     (enc_idx),
    .any       (enc_any)
  );

  always_comb begin
    pending_next          = pending;
    pending_next[enc_idx] = 1'b0;
  end

  assign valid = (state == SCAN) && enc_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pending <= '0;
      dir     <= 1'b0;
`ifdef MOVEM_COUNT_EN
      count   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            pending <= bus.mask;
            dir     <= bus.predec;
            state   <= (bus.mask != '0) ? SCAN : DONE;
`ifdef MOVEM_COUNT_EN
            count   <= '0;
`endif
          end
        end
        SCAN: begin
          if (valid && bus.idx_ready) begin
            pending <= pending_next;
            if (pending_next == '0) state <= DONE;
`ifdef MOVEM_COUNT_EN
            count   <= count + 1'b1;
`endif
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.idx       = valid ? enc_idx : '0;
  assign bus.idx_valid = valid;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
`ifdef MOVEM_COUNT_EN
  assign bus.count     = count;
`endif

endmodule

// File: tb/tb_movem_mask_sequencer.sv
// Self-checking bench for movem_mask_sequencer: directed scenarios plus
// randomized masks/back-pressure against a set-bit list model.
module tb_movem_mask_sequencer;

  logic clk;
  logic reset_n;
  int unsigned vectors;
  int unsigned miscompares;
  int unsigned got[$];

  movem_mask_sequencer_if #(.N(4)) bus ();

  movem_mask_sequencer #(.N(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected order: set bits ascending, or descending when predec.
  task automatic run_seq(input logic [15:0] m, input logic pd, input int unsigned pct,
                         input int unsigned hold_low, input bit restart_mid,
                         input bit start_in_done, input string name);
    int unsigned q[$];
    int unsigned hs;
    int unsigned cyc;
    bit fin;
    bit r;
    logic [3:0] e;
    hs = 0; cyc = 0; fin = 0;
    got.delete();
    if (!pd) begin
      for (int i = 0; i < 16; i++) if (m[i]) q.push_back(i);
    end else begin
      for (int i = 15; i >= 0; i--) if (m[i]) q.push_back(i);
    end
    @(negedge clk);
    bus.start = 1'b1; bus.mask = m; bus.predec = pd; bus.idx_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.mask = 16'($urandom); bus.predec = 1'($urandom);
    while (!fin) begin
      if (q.size() != 0) begin
        e = 4'(q[0]);
        vectors++;
        if (bus.idx_valid !== 1'b1 || bus.idx !== e || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          miscompares++;
          $display("FAIL %s scan[%0d]: idx_valid=%b idx=%0d busy=%b done=%b, want 1 %0d 1 0",
                   name, hs, bus.idx_valid, bus.idx, bus.busy, bus.done, e);
        end
        r = (cyc >= hold_low) && ($urandom_range(99) < pct);
        bus.start = restart_mid && (hs == 3);
        if (restart_mid && hs == 3) bus.mask = 16'h0001;
        bus.idx_ready = r;
        if (r) begin
          got.push_back(int'(bus.idx));
          void'(q.pop_front());
          hs++;
        end
      end else begin
        vectors++;
        if (bus.done !== 1'b1 || bus.idx_valid !== 1'b0 || bus.busy !== 1'b1 || bus.idx !== 4'd0) begin
          miscompares++;
          $display("FAIL %s done_pulse: done=%b idx_valid=%b busy=%b idx=%0d, want 1 0 1 0",
                   name, bus.done, bus.idx_valid, bus.busy, bus.idx);
        end
`ifdef MOVEM_COUNT_EN
        vectors++;
        if (bus.count !== 5'($countones(m))) begin
          miscompares++;
          $display("FAIL %s count: got %0d want %0d", name, bus.count, $countones(m));
        end
`endif
        bus.idx_ready = 1'($urandom);
        bus.start = start_in_done;
        bus.mask = 16'h0003;
        @(negedge clk);
        bus.start = 1'b0;
        vectors++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.idx_valid !== 1'b0 || bus.idx !== 4'd0) begin
          miscompares++;
          $display("FAIL %s after_done: done=%b busy=%b idx_valid=%b idx=%0d, want 0 0 0 0",
                   name, bus.done, bus.busy, bus.idx_valid, bus.idx);
        end
`ifdef MOVEM_COUNT_EN
        vectors++;
        if (bus.count !== 5'($countones(m))) begin
          miscompares++;
          $display("FAIL %s count_hold: got %0d want %0d", name, bus.count, $countones(m));
        end
`endif
        fin = 1;
      end
      if (!fin) begin
        @(negedge clk);
        cyc++;
        if (cyc > 300) begin
          miscompares++;
          $display("FAIL %s timeout: %0d handshakes, %0d indices still expected", name, hs, q.size());
          fin = 1;
        end
      end
    end
    bus.idx_ready = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.mask = 16'hFFFF; bus.predec = 1'b0; bus.idx_ready = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.idx !== 4'd0 || bus.idx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: idx=%0d idx_valid=%b busy=%b done=%b, want all 0",
               bus.idx, bus.idx_valid, bus.busy, bus.done);
    end
`ifdef MOVEM_COUNT_EN
    vectors++;
    if (bus.count !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_count: got %0d want 0", bus.count);
    end
`endif
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.idx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ready_no_effect: idx_valid=%b busy=%b done=%b, want 0 0 0",
               bus.idx_valid, bus.busy, bus.done);
    end
    bus.idx_ready = 1'b0;
  endtask

  task automatic test_empty_mask();
    run_seq(16'h0000, 1'b0, 100, 0, 1'b0, 1'b0, "empty_mask");
  endtask

  task automatic test_ascending();
    run_seq(16'h8101, 1'b0, 100, 0, 1'b0, 1'b0, "asc_8101");
  endtask

  task automatic test_predec_decoder();
    logic [15:0] onehot_exp [3];
    logic [15:0] dec;
    onehot_exp[0] = 16'h8000; onehot_exp[1] = 16'h0100; onehot_exp[2] = 16'h0001;
    run_seq(16'h8101, 1'b1, 100, 0, 1'b0, 1'b0, "predec_8101");
    vectors++;
    if (got.size() != 3) begin
      miscompares++;
      $display("FAIL predec_len: got %0d indices want 3", got.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        dec = 16'h0001 << got[k];
        vectors++;
        if (dec !== onehot_exp[k]) begin
          miscompares++;
          $display("FAIL predec_decode[%0d]: got %h want %h", k, dec, onehot_exp[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    run_seq(16'h0006, 1'b0, 100, 3, 1'b0, 1'b0, "backpressure_0006");
  endtask

  task automatic test_restart_ignored();
    run_seq(16'hFFFF, 1'b0, 100, 0, 1'b1, 1'b0, "full_restart_asc");
    vectors++;
    if (got.size() != 16) begin
      miscompares++;
      $display("FAIL full_len: got %0d indices want 16", got.size());
    end
    run_seq(16'hFFFF, 1'b1, 70, 0, 1'b1, 1'b0, "full_restart_desc");
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0] exp_idx [3];
    exp_idx[0] = 4'd4; exp_idx[1] = 4'd5; exp_idx[2] = 4'd6;
    @(negedge clk);
    bus.start = 1'b1; bus.mask = 16'h00F0; bus.predec = 1'b0; bus.idx_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (bus.idx_valid !== 1'b1 || bus.idx !== exp_idx[k]) begin
        miscompares++;
        $display("FAIL rst_mid_idx[%0d]: valid=%b idx=%0d want 1 %0d", k, bus.idx_valid, bus.idx, exp_idx[k]);
      end
      if (k < 2) @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.idx !== 4'd0 || bus.idx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_async: idx=%0d idx_valid=%b busy=%b done=%b, want all 0",
               bus.idx, bus.idx_valid, bus.busy, bus.done);
    end
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_mid_no_done: done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
    end
    reset_n = 1'b1;
    bus.idx_ready = 1'b0;
    run_seq(16'h00F0, 1'b0, 60, 0, 1'b0, 1'b0, "rst_mid_restart");
  endtask

  task automatic test_back_to_back();
    run_seq(16'h0410, 1'b1, 100, 0, 1'b0, 1'b1, "start_in_done");
    run_seq(16'h0001, 1'b0, 100, 0, 1'b0, 1'b1, "single_bit");
    run_seq(16'h8000, 1'b1, 50, 1, 1'b0, 1'b0, "single_top");
  endtask

  task automatic test_random();
    logic [15:0] m;
    for (int n = 0; n < 40; n++) begin
      m = 16'($urandom);
      if ($urandom_range(3) == 0) m = m & 16'($urandom);
      if ($urandom_range(7) == 0) m = 16'h0000;
      run_seq(m, 1'($urandom), $urandom_range(100, 30), $urandom_range(2),
              1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_empty_mask();
    test_ascending();
    test_predec_decoder();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid_scan();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
